// File: rtl/spi_conf_rx.sv
`default_nettype none
// ============================================================================
// Module      : spi_conf_rx
// Description : SPI slave that receives 16-bit configuration words from the
//               ARM and commits them into three mode registers. spck, mosi
//               and ncs are asynchronous to ck_1356meg and are brought into
//               the ck_1356meg domain through SYNC_STAGES-deep synchronisers.
//               A frame is one ncs-low window of exactly 16 spck rising
//               edges, MSB first. Bits [15:12] select the target register
//               and bits [7:0] carry the value; bits [11:8] are ignored.
//
// Ports       : ck_1356meg  in   block clock, rising edge
//               rst         in   asynchronous active-high reset
//               spck        in   SPI clock (async)
//               mosi        in   SPI data, sampled on spck rising edge
//               ncs         in   SPI chip select, active low
//               conf_word   out  [7:0] configuration, [7:5] = major mode
//               divisor     out  [7:0] LF clock divisor
//               conf_enio   out  [7:0] HF generic-snoop configuration
//               conf_strobe out  one-cycle pulse on any register write
//               frame_err   out  one-cycle pulse on bad length / bad command
//
// Revision    : 1.0  initial release
// ============================================================================
module spi_conf_rx #(
    parameter int         SYNC_STAGES = 2,      // legal range 2..4
    parameter logic [7:0] CONF_RESET  = 8'hE0   // major mode 111: all off
) (
    input  logic       ck_1356meg,
    input  logic       rst,
    input  logic       spck,
    input  logic       mosi,
    input  logic       ncs,
    output logic [7:0] conf_word,
    output logic [7:0] divisor,
    output logic [7:0] conf_enio,
    output logic       conf_strobe,
    output logic       frame_err
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SHIFT  = 2'd1;
    localparam logic [1:0] c_COMMIT = 2'd2;
    localparam logic [1:0] c_RESYNC = 2'd3;

    localparam logic [4:0] c_FRAME_BITS = 5'd16;
    localparam logic [4:0] c_CNT_SAT    = 5'd17;
    localparam logic [2:0] c_FLUSH_END  = 3'(SYNC_STAGES);

    localparam logic [3:0] c_CMD_CONF = 4'b0001;
    localparam logic [3:0] c_CMD_DIV  = 4'b0010;
    localparam logic [3:0] c_CMD_ENIO = 4'b0100;

    // ------------------------------------------------------------------
    // Input synchronisers. Bit 0 is the first stage; the MSB is the
    // synchronised copy used by the rest of the design.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_spck_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_ncs_sync;
    logic                   r_spck_d;
    logic                   r_ncs_d;

    always_ff @(posedge ck_1356meg or posedge rst) begin
        if (rst) begin
            r_spck_sync <= '0;
            r_mosi_sync <= '0;
            r_ncs_sync  <= '1;
            r_spck_d    <= 1'b0;
            r_ncs_d     <= 1'b1;
        end else begin
            r_spck_sync <= {r_spck_sync[SYNC_STAGES-2:0], spck};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
            r_spck_d    <= r_spck_sync[SYNC_STAGES-1];
            r_ncs_d     <= r_ncs_sync[SYNC_STAGES-1];
        end
    end

    logic w_spck_s;
    logic w_mosi_s;
    logic w_ncs_s;
    logic w_spck_rise;
    logic w_ncs_rise;
    logic w_ncs_fall;

    assign w_spck_s    = r_spck_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_ncs_s     = r_ncs_sync[SYNC_STAGES-1];
    assign w_spck_rise =  w_spck_s & ~r_spck_d;
    assign w_ncs_rise  =  w_ncs_s  & ~r_ncs_d;
    assign w_ncs_fall  = ~w_ncs_s  &  r_ncs_d;

    // ------------------------------------------------------------------
    // Frame state machine and configuration registers.
    // ------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [4:0]  r_bit_cnt;
    logic [15:0] r_shift_reg;
    // After reset the synchroniser holds its reset pattern, not the real
    // pins. RESYNC only trusts the synced ncs once the chain has been
    // refilled from the pins, so a frame already running at reset release
    // is skipped silently instead of being seen as a short frame.
    logic [2:0]  r_flush;

    always_ff @(posedge ck_1356meg or posedge rst) begin
        if (rst) begin
            r_state     <= c_RESYNC;
            r_bit_cnt   <= '0;
            r_shift_reg <= '0;
            r_flush     <= '0;
            conf_word   <= CONF_RESET;
            divisor     <= 8'd0;
            conf_enio   <= 8'd0;
            conf_strobe <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            conf_strobe <= 1'b0;
            frame_err   <= 1'b0;

            case (r_state)
                c_RESYNC: begin
                    if (r_flush != c_FLUSH_END) begin
                        r_flush <= r_flush + 3'd1;
                    end else if (w_ncs_s) begin
                        r_state <= c_IDLE;
                    end
                end

                c_IDLE: begin
                    if (w_ncs_fall) begin
                        r_bit_cnt   <= '0;
                        r_shift_reg <= '0;
                        r_state     <= c_SHIFT;
                    end
                end

                c_SHIFT: begin
                    // The ncs edge takes priority: an spck edge landing in
                    // the same cycle is dropped, leaving the count short.
                    if (w_ncs_rise) begin
                        if (r_bit_cnt == c_FRAME_BITS) begin
                            r_state <= c_COMMIT;
                        end else begin
                            frame_err <= 1'b1;
                            r_state   <= c_IDLE;
                        end
                    end else if (w_spck_rise && !w_ncs_s) begin
                        r_shift_reg <= {r_shift_reg[14:0], w_mosi_s};
                        if (r_bit_cnt != c_CNT_SAT) begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end
                end

                c_COMMIT: begin
                    case (r_shift_reg[15:12])
                        c_CMD_CONF: begin
                            conf_word   <= r_shift_reg[7:0];
                            conf_strobe <= 1'b1;
                        end
                        c_CMD_DIV: begin
                            divisor     <= r_shift_reg[7:0];
                            conf_strobe <= 1'b1;
                        end
                        c_CMD_ENIO: begin
                            conf_enio   <= r_shift_reg[7:0];
                            conf_strobe <= 1'b1;
                        end
                        default: begin
                            frame_err <= 1'b1;
                        end
                    endcase
                    r_state <= c_IDLE;
                end

                default: begin
                    r_state <= c_RESYNC;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
